umi_rw_host_arbiter: RTL
========================

# umi_rw_host_arbiter

Shares a single UMI host port between an AXI read converter (read port) and an AXI write converter (write port). Requests are arbitrated round-robin, and a grant is held for the whole UMI message, until the EOM beat. Responses are steered back to the originating port by response opcode. Per-port outstanding-message counters provide flow control and detect unexpected responses.

## Interface
Parameters:
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 64, UMI data width
- OUTW, 4, outstanding counter width; at most 2^OUTW-1 messages in flight per port

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- rd_req_valid/rd_req_ready  in/out  1  read-port request handshake
- rd_req_cmd, rd_req_dstaddr, rd_req_srcaddr, rd_req_data  in  CW/AW/AW/DW  read-port request fields
- rd_resp_valid/rd_resp_ready  out/in  1  read-port response handshake
- rd_resp_cmd, rd_resp_dstaddr, rd_resp_srcaddr, rd_resp_data  out  CW/AW/AW/DW  read-port response fields
- wr_req_* and wr_resp_*  same set as the rd_* ports, for the write port
- uhost_req_valid/uhost_req_ready  out/in  1  shared request handshake
- uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data  out  CW/AW/AW/DW  shared request fields
- uhost_resp_valid/uhost_resp_ready  in/out  1  shared response handshake
- uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data  in  CW/AW/AW/DW  shared response fields
- err_unexpected  out  1  sticky; a response arrived with no matching outstanding message

## Operation
- Request arbiter FSM:
  - States: IDLE, LOCK_RD, LOCK_WR.
  - IDLE: the eligible port wins; if both are eligible, round-robin pointer `last` decides (the port not granted last time wins).
  - IDLE grant is combinational in the same cycle. A winning beat with eom=1 completes in IDLE; eom=0 moves to LOCK_x.
  - LOCK_x: only port x is forwarded. An eom=1 handshake from x returns to IDLE and sets `last`=x.
- Eligibility of port x: req_valid=1 and cnt_x < 2^OUTW-1. Eligibility is checked only at message start; a locked message is never stalled by its counter.
- Request mux:
  - Granted port's fields are forwarded combinationally.
  - uhost_req_valid = granted valid; granted port's req_ready = uhost_req_ready; the other port's ready = 0.
- Counting: cnt_x increments on an eom=1 request handshake from x whose opcode ≠ UMI_REQ_POSTED. Posted writes are never counted.
- Response routing, by decoded opcode:
  - UMI_RESP_READ → rd port
  - UMI_RESP_WRITE → wr port
  - any other opcode → sunk
- Routed responses: fields are broadcast to both ports; only the target's resp_valid is asserted; uhost_resp_ready = target resp_ready.
- Sunk responses: uhost_resp_ready=1, err_unexpected set.
- On an eom=1 response handshake to port x:
  - cnt_x decrements.
  - If cnt_x==0 at that time, the response is still delivered, cnt_x stays 0 (no underflow), and err_unexpected is set.
- Simultaneous increment and decrement on the same counter in one cycle: value unchanged.
- err_unexpected is cleared only by reset.

## Timing
- Zero-cycle latency on both paths: no storage in the datapath, pure muxing.
- Registered state: FSM, last, cnt_rd, cnt_wr, err_unexpected.
- Reset values:
  - FSM=IDLE, last=wr (read port wins first tie), counters=0, err_unexpected=0.
  - All valid/ready outputs 0, except uhost_resp_ready, which equals the routed target ready.
  - Data outputs follow their inputs.
- A valid must not depend on ready: uhost_req_valid is a function only of port valids and state.
- Handshake rule: a port's valid and fields are held until ready. A granted message never changes grant mid-message.
- Reset mid-message: FSM returns to IDLE and counters clear. In-flight responses arriving after reset are flagged err_unexpected.

## Structure
- Shared package/header: UMI opcode constants and the eom bit position from umi_messages.vh. Decode through umi_unpack; no new constants.
- Sub-module umi_outstanding_ctr (parameter OUTW): inc, dec, full, empty, underflow flag. Instanced twice.

## Test plan
- Single read port: 3 read requests with eom=1 → 3 host beats, cnt_rd=3; 3 UMI_RESP_READ responses → delivered to rd port, cnt_rd=0, err_unexpected=0.
- Both ports valid every cycle, single-beat messages → grants alternate rd, wr, rd, wr…; the read port wins the first tie after reset.
- Write message of 4 beats (eom only on beat 4) with the read port valid throughout → 4 consecutive wr beats, then rd granted.
- OUTW=2: 3 reads issued with no responses → the 4th read is stalled (rd_req_ready=0) while write requests still pass; one response → the read proceeds next cycle.
- UMI_REQ_POSTED writes ×5 → cnt_wr stays 0. An injected UMI_RESP_WRITE → delivered to wr port, err_unexpected=1.
- Response opcode UMI_REQ_READ on uhost_resp → sunk with uhost_resp_ready=1, no port valid, err_unexpected=1.
- Same-cycle eom request and eom response on rd with cnt_rd=2 → cnt_rd stays 2.

Source files
------------

// File: rtl/umi_rw_host_arbiter_pkg.sv
// rtl/umi_rw_host_arbiter_pkg.sv - UMI opcode constants, command field positions and arbiter state type
//
// Purpose: shared definitions for the read/write host arbiter. Opcode values and
//          the eom bit position mirror umi_messages.vh. umi_unpack turns the
//          opcode and eom fields of a command into a decoded record.
// Ports:   none (package)
package umi_rw_host_arbiter_pkg;

  localparam int UMI_OPCODE_LSB = 0;
  localparam int UMI_OPCODE_W   = 5;
  localparam int UMI_EOM_BIT    = 22;

  localparam logic [UMI_OPCODE_W-1:0] UMI_REQ_READ   = 5'h01;
  localparam logic [UMI_OPCODE_W-1:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [UMI_OPCODE_W-1:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [UMI_OPCODE_W-1:0] UMI_RESP_READ  = 5'h02;
  localparam logic [UMI_OPCODE_W-1:0] UMI_RESP_WRITE = 5'h04;

  typedef struct packed {
    logic [UMI_OPCODE_W-1:0] opcode;
    logic                    eom;
  } umi_dec_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_LOCK_RD = 2'd1,
    ARB_LOCK_WR = 2'd2
  } arb_state_t;

  // Callers pass only the opcode and eom slices of the command so that no
  // command bit goes unread.
  function automatic umi_dec_t umi_unpack(input logic [UMI_OPCODE_W-1:0] opcode_field,
                                          input logic                    eom_field);
    umi_dec_t d;
    d.opcode = opcode_field;
    d.eom    = eom_field;
    return d;
  endfunction

endpackage

// File: rtl/umi_rw_host_arbiter_ctr.sv
// rtl/umi_rw_host_arbiter_ctr.sv - saturating outstanding-message counter
//
// Purpose: counts messages in flight for one port.
// Ports:   clk, nreset (async active-low)
//          inc       - one more message issued
//          dec       - one message completed
//          cnt       - current count
//          full      - cnt at its maximum (2^OUTW-1)
//          empty     - cnt is zero
//          underflow - dec requested while empty (count holds at 0)
module umi_outstanding_ctr #(
  parameter int OUTW = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            inc,
  input  logic            dec,
  output logic [OUTW-1:0] cnt,
  output logic            full,
  output logic            empty,
  output logic            underflow
);

  localparam logic [OUTW-1:0] CNT_ONE = OUTW'(1);

  assign full      = (cnt == '1);
  assign empty     = (cnt == '0);
  assign underflow = dec & empty;

  // inc and dec together cancel out, including at the empty/full limits.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec && !inc && !empty) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/umi_rw_host_arbiter.sv
// rtl/umi_rw_host_arbiter.sv - shares one UMI host port between an AXI read and an AXI write converter
//
// Purpose: round-robin request arbitration with per-message grant lock,
//          opcode-based response steering, outstanding-message flow control
//          and a sticky unexpected-response flag. Zero-latency, no datapath storage.
// Ports:   clk, nreset (async active-low)
//          rd_req_* / wr_req_*     - request streams from the read/write converters
//          rd_resp_* / wr_resp_*   - response streams back to the converters
//          uhost_req_*             - shared UMI request stream
//          uhost_resp_*            - shared UMI response stream
//          err_unexpected          - sticky: response with no outstanding message
module umi_rw_host_arbiter
  import umi_rw_host_arbiter_pkg::*;
#(
  parameter int CW   = 32,
  parameter int AW   = 64,
  parameter int DW   = 64,
  parameter int OUTW = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [CW-1:0] rd_req_cmd,
  input  logic [AW-1:0] rd_req_dstaddr,
  input  logic [AW-1:0] rd_req_srcaddr,
  input  logic [DW-1:0] rd_req_data,
  output logic          rd_resp_valid,
  input  logic          rd_resp_ready,
  output logic [CW-1:0] rd_resp_cmd,
  output logic [AW-1:0] rd_resp_dstaddr,
  output logic [AW-1:0] rd_resp_srcaddr,
  output logic [DW-1:0] rd_resp_data,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [CW-1:0] wr_req_cmd,
  input  logic [AW-1:0] wr_req_dstaddr,
  input  logic [AW-1:0] wr_req_srcaddr,
  input  logic [DW-1:0] wr_req_data,
  output logic          wr_resp_valid,
  input  logic          wr_resp_ready,
  output logic [CW-1:0] wr_resp_cmd,
  output logic [AW-1:0] wr_resp_dstaddr,
  output logic [AW-1:0] wr_resp_srcaddr,
  output logic [DW-1:0] wr_resp_data,
  output logic          uhost_req_valid,
  input  logic          uhost_req_ready,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_resp_valid,
  output logic          uhost_resp_ready,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          err_unexpected
);

  localparam int OPH = UMI_OPCODE_LSB + UMI_OPCODE_W - 1;

  arb_state_t state_q, state_d;
  logic       last_wr_q, last_wr_d;    // 1: write port was granted last
  logic       grant_rd, grant_wr;
  logic       rd_hs, wr_hs;
  logic       rd_elig, wr_elig;
  umi_dec_t   rd_dec, wr_dec, resp_dec;

  logic [OUTW-1:0] cnt_rd, cnt_wr;
  logic rd_full, rd_empty, rd_underflow;
  logic wr_full, wr_empty, wr_underflow;
  logic inc_rd, dec_rd, inc_wr, dec_wr;
  logic resp_is_rd, resp_is_wr, resp_sink;

  assign rd_dec   = umi_unpack(rd_req_cmd[OPH:UMI_OPCODE_LSB], rd_req_cmd[UMI_EOM_BIT]);
  assign wr_dec   = umi_unpack(wr_req_cmd[OPH:UMI_OPCODE_LSB], wr_req_cmd[UMI_EOM_BIT]);
  assign resp_dec = umi_unpack(uhost_resp_cmd[OPH:UMI_OPCODE_LSB], uhost_resp_cmd[UMI_EOM_BIT]);

  // Counter limit only gates the start of a message; locked states ignore it.
  assign rd_elig = rd_req_valid & ~rd_full;
  assign wr_elig = wr_req_valid & ~wr_full;

  assign rd_hs = grant_rd & rd_req_valid & uhost_req_ready;
  assign wr_hs = grant_wr & wr_req_valid & uhost_req_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ARB_IDLE;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ARB_IDLE: begin
        if (rd_elig && (!wr_elig || last_wr_q)) grant_rd = 1'b1;
        else if (wr_elig)                       grant_wr = 1'b1;
      end
      ARB_LOCK_RD: grant_rd = 1'b1;
      ARB_LOCK_WR: grant_wr = 1'b1;
      default: ;
    endcase
    if (rd_hs) begin
      if (rd_dec.eom) begin
        state_d   = ARB_IDLE;
        last_wr_d = 1'b0;
      end else begin
        state_d = ARB_LOCK_RD;
      end
    end
    if (wr_hs) begin
      if (wr_dec.eom) begin
        state_d   = ARB_IDLE;
        last_wr_d = 1'b1;
      end else begin
        state_d = ARB_LOCK_WR;
      end
    end
  end

  // Request mux: grants never depend on ready, so valid stays ready-independent.
  assign uhost_req_valid   = (grant_rd & rd_req_valid) | (grant_wr & wr_req_valid);
  assign uhost_req_cmd     = grant_wr ? wr_req_cmd     : rd_req_cmd;
  assign uhost_req_dstaddr = grant_wr ? wr_req_dstaddr : rd_req_dstaddr;
  assign uhost_req_srcaddr = grant_wr ? wr_req_srcaddr : rd_req_srcaddr;
  assign uhost_req_data    = grant_wr ? wr_req_data    : rd_req_data;
  assign rd_req_ready      = grant_rd & uhost_req_ready;
  assign wr_req_ready      = grant_wr & uhost_req_ready;

  // Response steering by opcode; anything else is drained here.
  assign resp_is_rd = (resp_dec.opcode == UMI_RESP_READ);
  assign resp_is_wr = (resp_dec.opcode == UMI_RESP_WRITE);
  assign resp_sink  = ~resp_is_rd & ~resp_is_wr;

  assign rd_resp_valid    = uhost_resp_valid & resp_is_rd;
  assign wr_resp_valid    = uhost_resp_valid & resp_is_wr;
  assign uhost_resp_ready = resp_is_rd ? rd_resp_ready :
                            resp_is_wr ? wr_resp_ready : 1'b1;

  assign rd_resp_cmd     = uhost_resp_cmd;
  assign rd_resp_dstaddr = uhost_resp_dstaddr;
  assign rd_resp_srcaddr = uhost_resp_srcaddr;
  assign rd_resp_data    = uhost_resp_data;
  assign wr_resp_cmd     = uhost_resp_cmd;
  assign wr_resp_dstaddr = uhost_resp_dstaddr;
  assign wr_resp_srcaddr = uhost_resp_srcaddr;
  assign wr_resp_data    = uhost_resp_data;

  // Posted writes get no response, so they are never counted.
  assign inc_rd = rd_hs & rd_dec.eom & (rd_dec.opcode != UMI_REQ_POSTED);
  assign inc_wr = wr_hs & wr_dec.eom & (wr_dec.opcode != UMI_REQ_POSTED);
  assign dec_rd = rd_resp_valid & rd_resp_ready & resp_dec.eom;
  assign dec_wr = wr_resp_valid & wr_resp_ready & resp_dec.eom;

  umi_outstanding_ctr #(.OUTW(OUTW)) u_rd_ctr (
    .clk       (clk),
    .nreset    (nreset),
    .inc       (inc_rd),
    .dec       (dec_rd),
    .cnt       (cnt_rd),
    .full      (rd_full),
    .empty     (rd_empty),
    .underflow (rd_underflow)
  );

  umi_outstanding_ctr #(.OUTW(OUTW)) u_wr_ctr (
    .clk       (clk),
    .nreset    (nreset),
    .inc       (inc_wr),
    .dec       (dec_wr),
    .cnt       (cnt_wr),
    .full      (wr_full),
    .empty     (wr_empty),
    .underflow (wr_underflow)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_unexpected <= 1'b0;
    end else if ((uhost_resp_valid && resp_sink) || rd_underflow || wr_underflow) begin
      err_unexpected <= 1'b1;
    end
  end

endmodule
